mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single-ported unified memory between instruction fetch (IF) and load/store (LS) in the multicycle RISC-V core.
// - Grants one requester at a time, drives the memory strobes, waits the fixed memory latency and returns read data or a write completion.
// - Sits between the main control FSM / datapath requesters and the memory.
// PARAMETERS
// - ADDR_W       32  address width
// - DATA_W       32  data width
// - MEM_LATENCY  2   cycles from the mem_rd/mem_wr pulse to valid mem_rdata; legal range 1..15, 0 is a compile-time $error
// PORTS
// - CLK        in   1       clock, rising edge
// - RST        in   1       reset, asynchronous, active-low
// - if_req     in   1       IF request; held until if_gnt
// - if_addr    in   ADDR_W  IF address; stable while if_req=1
// - if_gnt     out  1       IF request accepted (1-cycle pulse)
// - if_rvalid  out  1       IF read data valid (1-cycle pulse)
// - if_rdata   out  DATA_W  IF read data
// - ls_req     in   1       LS request; held until ls_gnt
// - ls_we      in   1       1 = write, 0 = read
// - ls_addr    in   ADDR_W  LS address
// - ls_wdata   in   DATA_W  LS write data
// - ls_gnt     out  1       LS request accepted (1-cycle pulse)
// - ls_rvalid  out  1       LS completion, read data valid (1-cycle pulse)
// - ls_rdata   out  DATA_W  LS read data (0 on write completion)
// - mem_rd     out  1       memory read strobe
// - mem_wr     out  1       memory write strobe
// - mem_addr   out  ADDR_W  memory address
// - mem_wdata  out  DATA_W  memory write data
// - mem_rdata  in   DATA_W  memory read data
// - busy       out  1       1 when state != IDLE
// BEHAVIOUR
// - States: IDLE, ACCESS, WAIT, RESP; reset state is IDLE.
// - While RST=0: every output is 0; owner, we_q, addr_q, wdata_q, rdata_q and cnt are cleared; last_owner = IF.
// - IDLE:
//   - If any req is high, a winner is chosen: LS beats IF by default.
//   - The winner's gnt is driven combinationally in the same cycle.
//   - addr/we/wdata are latched (IF: we=0, wdata=0); next state is ACCESS. Otherwise stay in IDLE.
// - ACCESS (cycle t), exactly one cycle:
//   - mem_rd = ~we_q, mem_wr = we_q, mem_addr = addr_q, mem_wdata = wdata_q.
//   - cnt <= MEM_LATENCY-1; next state is WAIT.
// - WAIT (cycles t+1 .. t+MEM_LATENCY): mem_* outputs are 0 and cnt decrements.
//   - When cnt==0: rdata_q <= (we_q ? 0 : mem_rdata), next state is RESP.
// - RESP (cycle t+MEM_LATENCY+1): the owner's rvalid = 1 and its rdata = rdata_q; next state is IDLE.
// - rdata of the non-owner, and of both requesters outside RESP, is 0.
// - Latency: gnt at cycle t-1 gives rvalid at t+MEM_LATENCY+1.
// - A new grant is only possible from IDLE, so back-to-back requests leave one IDLE bubble.
// - req asserted outside IDLE is ignored: no gnt, and request fields are not sampled.
// - Simultaneous if_req and ls_req in IDLE: exactly one gnt. The loser keeps req high and is granted in the next IDLE.
// - Writes complete with rvalid like reads; ls_rdata = 0 on a write completion.
// - Reset mid-operation (any non-IDLE state): transaction dropped, no rvalid, back to IDLE.
//   - A write strobed before the reset is not undone.
// - cnt is 4 bits wide and never wraps: it is loaded only in ACCESS and decremented only while nonzero.
// CONFIGURATION
// - MEM_ARB_RR_EN defined: round-robin on contention.
//   - When both req are high in IDLE, the grant goes to the requester that is not last_owner.
//   - last_owner updates on every grant and resets to IF, so the first contention goes to LS.
// - MEM_ARB_RR_EN undefined: fixed priority, LS always wins; the last_owner register is not built.
// TESTING
// - Reset: hold RST=0 with both req=1 -> all outputs 0, busy=0, no gnt. Release RST -> LS granted next cycle.
// - IF read, MEM_LATENCY=2, if_addr=0x100 at cycle 0:
//   - if_gnt at cycle 0; mem_rd=1 with mem_addr=0x100 at cycle 1.
//   - mem_rdata=0xDEADBEEF at cycle 3 -> if_rvalid=1 with if_rdata=0xDEADBEEF at cycle 4.
// - LS write, ls_addr=0x40, ls_wdata=0x12345678: one-cycle mem_wr=1 with those values, mem_rd=0. ls_rvalid at gnt+L+2 with ls_rdata=0.
// - Contention: if_req=ls_req=1 held for two rounds.
//   - Fixed priority: LS, then IF.
//   - With MEM_ARB_RR_EN: LS, then IF, then LS when both are re-requested.
// - Reset mid-WAIT: RST=0 for 1 cycle -> no rvalid, busy=0. The next IF read returns correct data with nominal latency.
// - Latency sweep MEM_LATENCY=1 and 4: rvalid exactly L+2 cycles after gnt; exactly one mem strobe per transaction.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/grant/response bundle between the IF and LS requesters, the arbiter and the memory.
// Handshake: a requester raises req with stable fields and holds it until gnt; gnt and rvalid are one-cycle pulses.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side: takes requests and read data, drives grants, responses and strobes.
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store with fixed latency.
// Optional MEM_ARB_RR_EN: round-robin on contention instead of fixed LS priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                CLK,
  input  logic                RST,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t            state, state_nxt;
  logic              owner;  // 0 = IF, 1 = LS
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        cnt;
  logic              pick_ls;
  logic              any_req;

  assign any_req = bus.if_req | bus.ls_req;

`ifdef MEM_ARB_RR_EN
  logic last_owner;

  // On contention, hand the port to whoever did not own it last.
  assign pick_ls = bus.ls_req & (~bus.if_req | ~last_owner);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_owner <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_owner <= pick_ls;
    end
  end
`else
  assign pick_ls = bus.ls_req;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_req) begin
          owner   <= pick_ls;
          we_q    <= pick_ls & bus.ls_we;
          addr_q  <= pick_ls ? bus.ls_addr : bus.if_addr;
          wdata_q <= pick_ls ? bus.ls_wdata : '0;
        end
        ACCESS: cnt <= CNT_LOAD;
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             rdata_q <= we_q ? '0 : bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.if_gnt    = 1'b0;
    bus.ls_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.ls_rvalid = 1'b0;
    bus.ls_rdata  = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: begin
        // Grant is combinational; gate with reset so nothing leaks while held in reset.
        if (RST && any_req) begin
          bus.ls_gnt = pick_ls;
          bus.if_gnt = ~pick_ls;
          state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_rd    = ~we_q;
        bus.mem_wr    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        if (owner) begin
          bus.ls_rvalid = 1'b1;
          bus.ls_rdata  = rdata_q;
        end else begin
          bus.if_rvalid = 1'b1;
          bus.if_rdata  = rdata_q;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main instance at latency 2, side instances at latency 1 and 4.
module tb_mem_port_arbiter;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();

  logic       busy, busy1, busy4;
  logic [1:0] st, st1, st4;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) u_dut (
    .CLK(CLK), .RST(RST), .bus(bus), .busy(busy), .state_dbg(st));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .bus(bus1), .busy(busy1), .state_dbg(st1));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .bus(bus4), .busy(busy4), .state_dbg(st4));

  // Memory models: data is only valid exactly L cycles after the read strobe.
  logic [31:0] rd_val, rd_val1, rd_val4;
  logic [15:0] pipe = '0, pipe1 = '0, pipe4 = '0;
  int rd_cnt = 0, wr_cnt = 0, rd_cnt1 = 0, wr_cnt1 = 0, rd_cnt4 = 0, wr_cnt4 = 0;

  always @(posedge CLK) begin
    pipe  <= {pipe[14:0],  bus.mem_rd};
    pipe1 <= {pipe1[14:0], bus1.mem_rd};
    pipe4 <= {pipe4[14:0], bus4.mem_rd};
    if (bus.mem_rd)  rd_cnt  <= rd_cnt + 1;
    if (bus.mem_wr)  wr_cnt  <= wr_cnt + 1;
    if (bus1.mem_rd) rd_cnt1 <= rd_cnt1 + 1;
    if (bus1.mem_wr) wr_cnt1 <= wr_cnt1 + 1;
    if (bus4.mem_rd) rd_cnt4 <= rd_cnt4 + 1;
    if (bus4.mem_wr) wr_cnt4 <= wr_cnt4 + 1;
  end

  assign bus.mem_rdata  = pipe[1]  ? rd_val  : 32'hBADBAD00;
  assign bus1.mem_rdata = pipe1[0] ? rd_val1 : 32'hBADBAD01;
  assign bus4.mem_rdata = pipe4[3] ? rd_val4 : 32'hBADBAD04;

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(output int n, output bit g_if, output bit g_ls);
    n = 0; g_if = 1'b0; g_ls = 1'b0;
    while (n < 20 && !(g_if || g_ls)) begin
      @(negedge CLK);
      n++;
      g_if = bus.if_gnt;
      g_ls = bus.ls_gnt;
    end
  endtask

  task automatic wait_rvalid(output int n, output bit v_if, output bit v_ls,
                             output logic [31:0] d_if, output logic [31:0] d_ls,
                             output bit gnt_seen);
    n = 0; v_if = 1'b0; v_ls = 1'b0; d_if = '0; d_ls = '0; gnt_seen = 1'b0;
    while (n < 20 && !(v_if || v_ls)) begin
      @(negedge CLK);
      n++;
      v_if = bus.if_rvalid;
      v_ls = bus.ls_rvalid;
      d_if = bus.if_rdata;
      d_ls = bus.ls_rdata;
      if (bus.if_gnt || bus.ls_gnt) gnt_seen = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n; bit v_if, v_ls, gs; logic [31:0] d_if, d_ls;
    RST = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h80; bus.ls_wdata = 32'hFFFF0000;
    rd_val = 32'h11112222;
    repeat (2) @(negedge CLK);
    checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.mem_rd, bus.mem_wr, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0000000", {bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.mem_rd, bus.mem_wr, busy});
    end
    checks++;
    if ((bus.mem_addr | bus.mem_wdata | bus.if_rdata | bus.ls_rdata) !== 32'h0 || st !== 2'd0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wdata=%h if_rdata=%h ls_rdata=%h st=%0d exp all 0",
               bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.ls_rdata, st);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({bus.ls_gnt, bus.if_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release_gnt got ls/if=%b exp 10", {bus.ls_gnt, bus.if_gnt});
    end
    @(posedge CLK); #1;
    bus.ls_req = 1'b0; bus.if_req = 1'b0;
    wait_rvalid(n, v_if, v_ls, d_if, d_ls, gs);
    checks++;
    if (!(v_ls && !v_if && n == 4 && d_ls === 32'h11112222)) begin
      errors++;
      $display("FAIL reset_first_read got v_ls=%0d v_if=%0d lat=%0d data=%h exp 1 0 4 11112222", v_ls, v_if, n, d_ls);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_ls_write();
    int rb, wb;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h40; bus.ls_wdata = 32'h12345678;
    @(negedge CLK);
    checks++;
    if ({bus.ls_gnt, bus.if_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL wr_gnt got ls/if=%b exp 10", {bus.ls_gnt, bus.if_gnt});
    end
    @(posedge CLK); #1;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_wdata = 32'h0; bus.ls_addr = 32'h0;
    rb = rd_cnt; wb = wr_cnt;
    @(negedge CLK);
    checks++;
    if ({bus.mem_wr, bus.mem_rd} !== 2'b10 || bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_strobe got wr/rd=%b addr=%h wdata=%h exp 10 00000040 12345678",
               {bus.mem_wr, bus.mem_rd}, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge CLK);
    checks++;
    if ({bus.mem_wr, bus.mem_rd, bus.ls_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL wr_wait_quiet got wr/rd/rv=%b exp 000", {bus.mem_wr, bus.mem_rd, bus.ls_rvalid});
    end
    repeat (2) @(negedge CLK);
    checks++;
    if (bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'h0 || bus.if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_complete got rvalid=%b rdata=%h if_rvalid=%b exp 1 00000000 0",
               bus.ls_rvalid, bus.ls_rdata, bus.if_rvalid);
    end
    checks++;
    if (wr_cnt - wb != 1 || rd_cnt - rb != 0) begin
      errors++;
      $display("FAIL wr_strobe_count got wr=%0d rd=%0d exp 1 0", wr_cnt - wb, rd_cnt - rb);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_if_read();
    int rb;
    bus.if_req = 1'b1; bus.if_addr = 32'h100; rd_val = 32'hDEADBEEF;
    @(negedge CLK);
    checks++;
    if ({bus.if_gnt, bus.ls_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL rd_gnt got if/ls=%b exp 10", {bus.if_gnt, bus.ls_gnt});
    end
    @(posedge CLK); #1;
    bus.if_req = 1'b0; bus.if_addr = 32'hFFF;
    rb = rd_cnt;
    @(negedge CLK);
    checks++;
    if ({bus.mem_rd, bus.mem_wr} !== 2'b10 || bus.mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL rd_strobe got rd/wr=%b addr=%h exp 10 00000100", {bus.mem_rd, bus.mem_wr}, bus.mem_addr);
    end
    @(negedge CLK);
    checks++;
    if (bus.mem_rd !== 1'b0 || busy !== 1'b1 || st !== 2'd2) begin
      errors++;
      $display("FAIL rd_wait got mem_rd=%b busy=%b st=%0d exp 0 1 2", bus.mem_rd, busy, st);
    end
    @(negedge CLK);
    checks++;
    if (bus.if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_early_rvalid got %b exp 0", bus.if_rvalid);
    end
    @(negedge CLK);
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hDEADBEEF || bus.ls_rvalid !== 1'b0 || bus.ls_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rd_resp got rvalid=%b rdata=%h ls_rvalid=%b ls_rdata=%h exp 1 deadbeef 0 00000000",
               bus.if_rvalid, bus.if_rdata, bus.ls_rvalid, bus.ls_rdata);
    end
    checks++;
    if (rd_cnt - rb != 1) begin
      errors++;
      $display("FAIL rd_strobe_count got %0d exp 1", rd_cnt - rb);
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || bus.if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle got busy=%b rvalid=%b exp 0 0", busy, bus.if_rvalid);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_contention();
    int n; bit g_if, g_ls, v_if, v_ls, gs; logic [31:0] d_if, d_ls;
    bit exp_r4_ls;
`ifdef MEM_ARB_RR_EN
    exp_r4_ls = 1'b0;
`else
    exp_r4_ls = 1'b1;
`endif
    // Round 1: both request, LS wins; IF stays pending through the LS transaction.
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h80;
    rd_val = 32'hA1A1A1A1;
    wait_gnt(n, g_if, g_ls);
    checks++;
    if ({g_ls, g_if} !== 2'b10) begin
      errors++;
      $display("FAIL cont_r1_gnt got ls/if=%b exp 10", {g_ls, g_if});
    end
    @(posedge CLK); #1;
    bus.ls_req = 1'b0;
    wait_rvalid(n, v_if, v_ls, d_if, d_ls, gs);
    checks++;
    if (!(v_ls && !v_if && d_ls === 32'hA1A1A1A1 && !gs && bus.if_rdata === 32'h0)) begin
      errors++;
      $display("FAIL cont_r1_resp got v_ls=%0d v_if=%0d d=%h gnt_seen=%0d if_rdata=%h exp 1 0 a1a1a1a1 0 0",
               v_ls, v_if, d_ls, gs, bus.if_rdata);
    end
    // Round 2: the pending IF is granted after a single IDLE bubble.
    rd_val = 32'hA2A2A2A2;
    wait_gnt(n, g_if, g_ls);
    checks++;
    if ({g_if, g_ls} !== 2'b10 || n != 1) begin
      errors++;
      $display("FAIL cont_r2_gnt got if/ls=%b bubble=%0d exp 10 1", {g_if, g_ls}, n);
    end
    @(posedge CLK); #1;
    bus.if_req = 1'b0;
    wait_rvalid(n, v_if, v_ls, d_if, d_ls, gs);
    checks++;
    if (!(v_if && !v_ls && d_if === 32'hA2A2A2A2 && bus.ls_rdata === 32'h0)) begin
      errors++;
      $display("FAIL cont_r2_resp got v_if=%0d v_ls=%0d d=%h ls_rdata=%h exp 1 0 a2a2a2a2 0", v_if, v_ls, d_if, bus.ls_rdata);
    end
    // Round 3: both re-request; LS wins in either arbitration mode.
    bus.if_req = 1'b1; bus.ls_req = 1'b1; rd_val = 32'hA3A3A3A3;
    wait_gnt(n, g_if, g_ls);
    checks++;
    if ({g_ls, g_if} !== 2'b10) begin
      errors++;
      $display("FAIL cont_r3_gnt got ls/if=%b exp 10", {g_ls, g_if});
    end
    @(posedge CLK); #1;
    wait_rvalid(n, v_if, v_ls, d_if, d_ls, gs);
    checks++;
    if (!(v_ls && d_ls === 32'hA3A3A3A3 && !gs)) begin
      errors++;
      $display("FAIL cont_r3_resp got v_ls=%0d d=%h gnt_seen=%0d exp 1 a3a3a3a3 0", v_ls, d_ls, gs);
    end
    // Round 4: both still high; fixed priority repeats LS, round-robin switches to IF.
    rd_val = 32'hA4A4A4A4;
    wait_gnt(n, g_if, g_ls);
    checks++;
    if ({g_ls, g_if} !== {exp_r4_ls, ~exp_r4_ls} || n != 1) begin
      errors++;
      $display("FAIL cont_r4_gnt got ls/if=%b bubble=%0d exp %b 1", {g_ls, g_if}, n, {exp_r4_ls, ~exp_r4_ls});
    end
    @(posedge CLK); #1;
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    wait_rvalid(n, v_if, v_ls, d_if, d_ls, gs);
    checks++;
    if ({v_ls, v_if} !== {exp_r4_ls, ~exp_r4_ls} || (exp_r4_ls ? d_ls : d_if) !== 32'hA4A4A4A4) begin
      errors++;
      $display("FAIL cont_r4_resp got v_ls/v_if=%b d_ls=%h d_if=%h exp %b a4a4a4a4",
               {v_ls, v_if}, d_ls, d_if, {exp_r4_ls, ~exp_r4_ls});
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    int n, stray; bit g_if, g_ls, v_if, v_ls, gs; logic [31:0] d_if, d_ls;
    bus.if_req = 1'b1; bus.if_addr = 32'h300; rd_val = 32'h33333333;
    wait_gnt(n, g_if, g_ls);
    @(posedge CLK); #1;
    bus.if_req = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || st !== 2'd0 || bus.if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state got busy=%b st=%0d rvalid=%b exp 0 0 0", busy, st, bus.if_rvalid);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge CLK);
      if (bus.if_rvalid || bus.ls_rvalid || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL mid_reset_dropped got %0d active cycles exp 0", stray);
    end
    @(posedge CLK); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h100; rd_val = 32'hCAFEF00D;
    wait_gnt(n, g_if, g_ls);
    @(posedge CLK); #1;
    bus.if_req = 1'b0;
    wait_rvalid(n, v_if, v_ls, d_if, d_ls, gs);
    checks++;
    if (!(g_if && v_if && n == 4 && d_if === 32'hCAFEF00D)) begin
      errors++;
      $display("FAIL mid_reset_recover got gnt=%0d v=%0d lat=%0d d=%h exp 1 1 4 cafef00d", g_if, v_if, n, d_if);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_latency_sweep();
    int t1, t4, nv1, nv4, rb1, rb4, wb1, wb4;
    logic [31:0] d1, d4;
    t1 = 0; t4 = 0; nv1 = 0; nv4 = 0; d1 = '0; d4 = '0;
    bus1.if_req = 1'b1; bus1.if_addr = 32'h10; rd_val1 = 32'h1111AAAA;
    bus4.if_req = 1'b1; bus4.if_addr = 32'h20; rd_val4 = 32'h4444BBBB;
    @(negedge CLK);
    checks++;
    if ({bus1.if_gnt, bus4.if_gnt} !== 2'b11) begin
      errors++;
      $display("FAIL sweep_gnt got l1/l4=%b exp 11", {bus1.if_gnt, bus4.if_gnt});
    end
    @(posedge CLK); #1;
    bus1.if_req = 1'b0; bus4.if_req = 1'b0;
    rb1 = rd_cnt1; rb4 = rd_cnt4; wb1 = wr_cnt1; wb4 = wr_cnt4;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (bus1.if_rvalid) begin nv1++; t1 = c; d1 = bus1.if_rdata; end
      if (bus4.if_rvalid) begin nv4++; t4 = c; d4 = bus4.if_rdata; end
    end
    checks++;
    if (nv1 != 1 || t1 != 3 || d1 !== 32'h1111AAAA) begin
      errors++;
      $display("FAIL sweep_l1 got count=%0d lat=%0d d=%h exp 1 3 1111aaaa", nv1, t1, d1);
    end
    checks++;
    if (nv4 != 1 || t4 != 6 || d4 !== 32'h4444BBBB) begin
      errors++;
      $display("FAIL sweep_l4 got count=%0d lat=%0d d=%h exp 1 6 4444bbbb", nv4, t4, d4);
    end
    checks++;
    if (rd_cnt1 - rb1 != 1 || rd_cnt4 - rb4 != 1 || wr_cnt1 - wb1 != 0 || wr_cnt4 - wb4 != 0) begin
      errors++;
      $display("FAIL sweep_strobes got rd1=%0d rd4=%0d wr1=%0d wr4=%0d exp 1 1 0 0",
               rd_cnt1 - rb1, rd_cnt4 - rb4, wr_cnt1 - wb1, wr_cnt4 - wb4);
    end
  endtask

  initial begin
    RST = 1'b0;
    bus.if_req = 1'b0;  bus.if_addr = '0;  bus.ls_req = 1'b0;  bus.ls_we = 1'b0;  bus.ls_addr = '0;  bus.ls_wdata = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.ls_req = 1'b0; bus1.ls_we = 1'b0; bus1.ls_addr = '0; bus1.ls_wdata = '0;
    bus4.if_req = 1'b0; bus4.if_addr = '0; bus4.ls_req = 1'b0; bus4.ls_we = 1'b0; bus4.ls_addr = '0; bus4.ls_wdata = '0;
    rd_val = '0; rd_val1 = '0; rd_val4 = '0;
    test_reset();
    test_ls_write();
    test_if_read();
    test_contention();
    test_reset_mid();
    test_latency_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
